// File: rtl/hdbn_encoder.sv
// hdbn_encoder: HDBn/AMI line encoder; an N_ZEROS+1 tag pipeline lets a zero run be rewritten
// as 0..0V or B0..0V before any of its symbols reach the registered ternary output.
module hdbn_encoder #(
    parameter int   N_ZEROS  = 3,
    parameter logic INIT_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       origin_data,
    input  logic       en,
    input  logic       hdb_mode,
    output logic [1:0] encoding_data,
    output logic [1:0] sym_type,
    output logic       encoding_data_instruction
);
    localparam int DEPTH = N_ZEROS + 1;
    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_MARK = 2'b01;
    localparam logic [1:0] T_B    = 2'b10;
    localparam logic [1:0] T_V    = 2'b11;

    logic [1:0] r_s [DEPTH];
    logic [2:0] r_zcnt;
    logic [3:0] r_fill;
    logic       r_parity;
    logic       r_last_pol;
    logic [1:0] w_tag_out;
    logic [1:0] w_sym;
    logic       w_sub;
    logic       w_pol;
    logic       w_primed;

    assign w_tag_out = r_s[N_ZEROS];
    assign w_sub     = hdb_mode && !origin_data && (r_zcnt == 3'(N_ZEROS));
    // V repeats the previous polarity; MARK and B alternate it
    assign w_pol     = (w_tag_out == T_MARK || w_tag_out == T_B) ? ~r_last_pol : r_last_pol;
    assign w_sym     = (w_tag_out == T_ZERO) ? 2'b00 : (w_pol ? 2'b01 : 2'b10);
    assign w_primed  = (r_fill == 4'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_s[i] <= T_ZERO;
            r_zcnt                    <= 3'd0;
            r_fill                    <= 4'd0;
            r_parity                  <= 1'b0;
            r_last_pol                <= INIT_POL;
            encoding_data             <= 2'b00;
            sym_type                  <= 2'b00;
            encoding_data_instruction <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < N_ZEROS; i++) r_s[i+1] <= r_s[i];
            r_s[0] <= origin_data ? T_MARK : (w_sub ? T_V : T_ZERO);
            // even pulse count since last V: first zero of the run becomes B
            if (w_sub && !r_parity) r_s[N_ZEROS] <= T_B;
            r_zcnt                    <= (w_sub || origin_data || !hdb_mode) ? 3'd0 : r_zcnt + 3'd1;
            r_parity                  <= w_sub ? 1'b0 : (r_parity ^ origin_data);
            r_last_pol                <= w_pol;
            r_fill                    <= w_primed ? r_fill : r_fill + 4'd1;
            encoding_data             <= w_sym;
            sym_type                  <= w_tag_out;
            encoding_data_instruction <= w_primed;
        end else begin
            encoding_data_instruction <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hdbn_encoder.sv
// tb_hdbn_encoder: vector tables, hand sequences and a random stream checked against an
// array-based HDBn reference model, run on N_ZEROS = 1, 3 and 5 instances in parallel.
module tb_hdbn_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       origin_data = 1'b0;
    logic       en = 1'b0;
    logic       hdb_mode = 1'b0;
    logic [1:0] ed1, st1, ed3, st3, ed5, st5;
    logic       in1, in3, in5;
    logic       en_q = 1'b0;

    always #5 clk = ~clk;

    hdbn_encoder #(.N_ZEROS(1)) dut1 (.clk(clk), .rst(rst), .origin_data(origin_data), .en(en),
        .hdb_mode(hdb_mode), .encoding_data(ed1), .sym_type(st1), .encoding_data_instruction(in1));
    hdbn_encoder #(.N_ZEROS(3)) dut3 (.clk(clk), .rst(rst), .origin_data(origin_data), .en(en),
        .hdb_mode(hdb_mode), .encoding_data(ed3), .sym_type(st3), .encoding_data_instruction(in3));
    hdbn_encoder #(.N_ZEROS(5)) dut5 (.clk(clk), .rst(rst), .origin_data(origin_data), .en(en),
        .hdb_mode(hdb_mode), .encoding_data(ed5), .sym_type(st5), .encoding_data_instruction(in5));

    typedef struct {
        int         g;
        bit         b;
        bit         m;
        logic [3:0] e;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] q1[$], q3[$], q5[$], qa[$], expq[$];
    bit         fb[$], fm[$];
    int         tests = 0, fails = 0, bad11 = 0, stray = 0;

    always @(posedge clk) en_q <= en;

    always @(negedge clk) begin
        if (in1) q1.push_back({ed1, st1});
        if (in3) q3.push_back({ed3, st3});
        if (in5) q5.push_back({ed5, st5});
        if (in3 && !en_q) stray++;
        if (ed1 == 2'b11 || ed3 == 2'b11 || ed5 == 2'b11) bad11++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input int g, input bit b, input bit m, input logic [3:0] e);
        vec_t v;
        v.g = g; v.b = b; v.m = m; v.e = e;
        vecs.push_back(v);
    endfunction

    // Tags per bit from the substitution rule, then a polarity pass; result {symbol, type}
    function automatic void model(input int n);
        int         len = fb.size();
        int         run = 0, pulses = 0, pol = -1;
        logic [1:0] tg[];
        logic [1:0] sym;
        tg = new[len];
        expq.delete();
        for (int i = 0; i < len; i++) begin
            if (fb[i]) begin
                tg[i] = 2'b01;
                pulses++;
                run = 0;
            end else begin
                tg[i] = 2'b00;
                run = fm[i] ? run + 1 : 0;
                if (run == n + 1) begin
                    tg[i] = 2'b11;
                    if (pulses % 2 == 0) tg[i-n] = 2'b10;
                    pulses = 0;
                    run = 0;
                end
            end
        end
        for (int i = 0; i < len; i++) begin
            if (tg[i] == 2'b01 || tg[i] == 2'b10) pol = -pol;
            sym = (tg[i] == 2'b00) ? 2'b00 : (pol > 0 ? 2'b01 : 2'b10);
            expq.push_back({sym, tg[i]});
        end
    endfunction

    task automatic strobe(input bit b, input bit m);
        @(negedge clk);
        origin_data = b;
        hdb_mode = m;
        en = 1'b1;
        fb.push_back(b);
        fm.push_back(m);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("reset encoding_data", ed3, 0);
        check("reset sym_type", st3, 0);
        check("reset instruction", in3, 0);
        @(negedge clk);
        q1.delete(); q3.delete(); q5.delete();
        fb.delete(); fm.delete();
        stray = 0;
        rst = 1'b1;
    endtask

    task automatic run_group(input int g);
        bit m = 1'b0;
        int k = 0;
        do_reset();
        foreach (vecs[i]) if (vecs[i].g == g) begin
            strobe(vecs[i].b, vecs[i].m);
            m = vecs[i].m;
        end
        repeat (4) strobe(1'b0, m);
        idle(3);
        foreach (vecs[i]) if (vecs[i].g == g) begin
            check($sformatf("group%0d sym%0d", g, k), k < q3.size() ? q3[k] : 4'bxxxx, vecs[i].e);
            k++;
        end
    endtask

    task automatic analyze(input int n);
        int mism = 0, run = 0, maxrun = 0, dc = 0, maxdc = 0;
        logic [1:0] sym;
        model(n);
        for (int k = 0; k < 3400; k++) begin
            if (k >= qa.size() || qa[k] !== expq[k]) mism++;
            if (k < qa.size()) begin
                sym = qa[k][3:2];
                run = (sym == 2'b00 && fm[k]) ? run + 1 : 0;
                if (run > maxrun) maxrun = run;
                dc += (sym == 2'b01) ? 1 : (sym == 2'b10 ? -1 : 0);
                if (dc > maxdc) maxdc = dc;
                if (-dc > maxdc) maxdc = -dc;
            end
        end
        check($sformatf("random N=%0d mismatches", n), mism, 0);
        check($sformatf("random N=%0d zero run within limit", n), maxrun <= n, 1);
        check($sformatf("random N=%0d dc bounded", n), maxdc <= 4, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit [15:0] pat = 16'b1100001000000001;
        int        mism;
        // AMI: 1,1,0,1 then 8 zeros
        add(0, 1, 0, 4'b0101); add(0, 1, 0, 4'b1001); add(0, 0, 0, 4'b0000); add(0, 1, 0, 4'b0101);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 4'b0000);
        // HDB3 from reset: B+ 0 0 V+
        add(1, 0, 1, 4'b0110); add(1, 0, 1, 4'b0000); add(1, 0, 1, 4'b0000); add(1, 0, 1, 4'b0111);
        // odd pulse count before each run: plain 000V, successive V alternate
        add(2, 1, 1, 4'b0101); add(2, 0, 1, 4'b0000); add(2, 0, 1, 4'b0000); add(2, 0, 1, 4'b0000);
        add(2, 0, 1, 4'b0111); add(2, 1, 1, 4'b1001); add(2, 0, 1, 4'b0000); add(2, 0, 1, 4'b0000);
        add(2, 0, 1, 4'b0000); add(2, 0, 1, 4'b1011);
        // even pulse count: B00V
        add(3, 1, 1, 4'b0101); add(3, 1, 1, 4'b1001); add(3, 0, 1, 4'b0110); add(3, 0, 1, 4'b0000);
        add(3, 0, 1, 4'b0000); add(3, 0, 1, 4'b0111);
        for (int g = 0; g < 4; g++) run_group(g);

        // gapless reference run of the stall pattern
        do_reset();
        for (int i = 0; i < 16; i++) strobe(pat[15-i], 1'b1);
        repeat (4) strobe(1'b0, 1'b1);
        idle(3);
        qa = q3;
        model(3);
        mism = 0;
        for (int k = 0; k < 16; k++) if (k >= qa.size() || qa[k] !== expq[k]) mism++;
        check("gapless pattern vs model", mism, 0);
        // same pattern with random en gaps
        do_reset();
        for (int i = 0; i < 20; i++) begin
            strobe(i < 16 ? pat[15-i] : 1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
        end
        idle(3);
        check("stall output count", q3.size(), qa.size());
        mism = 0;
        for (int k = 0; k < qa.size(); k++) if (k >= q3.size() || q3[k] !== qa[k]) mism++;
        check("stall sequence equals gapless", mism, 0);
        check("no pulse while en low", stray, 0);

        // asynchronous reset two zeros into a run
        do_reset();
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        q3.delete();
        rst = 1'b1;
        repeat (8) strobe(1'b0, 1'b1);
        idle(3);
        check("reset mid-run count", q3.size(), 4);
        check("reset mid-run B", q3.size() > 0 ? q3[0] : 4'bxxxx, 4'b0110);
        check("reset mid-run zero", q3.size() > 1 ? q3[1] : 4'bxxxx, 4'b0000);
        check("reset mid-run zero2", q3.size() > 2 ? q3[2] : 4'bxxxx, 4'b0000);
        check("reset mid-run V", q3.size() > 3 ? q3[3] : 4'bxxxx, 4'b0111);

        // random stream with an AMI window and en gaps, all three instances
        do_reset();
        for (int i = 0; i < 3400; i++) begin
            strobe($urandom_range(0, 9) < 4, !(i >= 1500 && i < 1800));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        repeat (6) strobe(1'b0, 1'b1);
        idle(3);
        qa = q1; analyze(1);
        qa = q3; analyze(3);
        qa = q5; analyze(5);
        check("symbol 11 never driven", bad11, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
